dmem_responder: RTL

- Data-memory responder: services the single-word Rd/Wr requests issued by the memory pipeline stage and answers with Done, Stall, CacheHit and err.
- Contains a direct-mapped, one-word-per-line, write-through, write-no-allocate cache in front of an internal backing word array with fixed miss latency.
- Drop-in stand-in for the data-side memory system, for pipeline bring-up and stall-path verification.

---
 rtl/dmem_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for pipeline bring-up.
// Accepts one Rd or Wr request at a time and answers with a one-cycle Done.
// A direct-mapped, one-word-per-line cache sits in front of a backing array.
// The cache is write-through and write-no-allocate, and the backing array
// answers after a fixed miss latency.
module dmem_responder #(
    parameter int LINES    = 8,
    parameter int MEM_AW   = 12,
    parameter int MISS_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    input  logic        cancel,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = MEM_AW - IDX;
    localparam int CNT_W = $clog2(MISS_LAT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESP      = 2'd2
    } stateT;

    stateT state, stateNext;

    // Miss-latency counter and the request latched at acceptance.
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [MEM_AW-1:0] reqWord;
    logic              reqWrite;
    logic              reqHit;

    // Cache storage. Only the valid bits carry reset state.
    logic [LINES-1:0] validBits;
    logic [TAG_W-1:0] tagArr  [LINES];
    logic [15:0]      dataArr [LINES];

    // Backing word array.
    logic [15:0] mem [2**MEM_AW];

    // Address split of the incoming request.
    logic [MEM_AW-1:0] inWord;
    logic [IDX-1:0]    inIndex;
    logic [TAG_W-1:0]  inTag;
    logic              inHit;
    logic              illegal;
    logic              request;

    assign inWord  = Addr[MEM_AW:1];
    assign inIndex = Addr[IDX:1];
    assign inTag   = Addr[MEM_AW:IDX+1];
    assign inHit   = validBits[inIndex] && (tagArr[inIndex] == inTag);
    assign request = Rd | Wr;
    assign illegal = Addr[0] | (Rd & Wr);

    // Fields of the latched request, used when a read miss fills its line.
    logic [IDX-1:0]   reqIndex;
    logic [TAG_W-1:0] reqTag;
    logic [15:0]      memRdata;

    assign reqIndex = reqWord[IDX-1:0];
    assign reqTag   = reqWord[MEM_AW-1:IDX];
    assign memRdata = mem[reqWord];

    // createdump has no functional effect. The upper address bits lie
    // above the backing store and are ignored.
    logic unusedBits;
    assign unusedBits = ^{createdump, Addr[15:MEM_AW+1]};

    // Decoded actions for this cycle.
    logic        accept;
    logic        memWe;
    logic        cacheWe;
    logic        fill;
    logic        doneNext;
    logic        hitNext;
    logic        errNext;
    logic [15:0] dataNext;

    // Next-state and action decode. Stall is combinational from here.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        memWe     = 1'b0;
        cacheWe   = 1'b0;
        fill      = 1'b0;
        doneNext  = 1'b0;
        hitNext   = 1'b0;
        errNext   = 1'b0;
        dataNext  = 16'h0000;
        Stall     = 1'b0;

        unique case (state)
            IDLE: begin
                if (request) begin
                    if (illegal) begin
                        stateNext = RESP;
                        doneNext  = 1'b1;
                        errNext   = 1'b1;
                    end else if (Rd) begin
                        if (inHit) begin
                            stateNext = RESP;
                            doneNext  = 1'b1;
                            hitNext   = 1'b1;
                            dataNext  = dataArr[inIndex];
                        end else begin
                            stateNext = MISS_WAIT;
                            cntNext   = CNT_W'(MISS_LAT);
                            accept    = 1'b1;
                            Stall     = 1'b1;
                        end
                    end else begin
                        // Write-through: the backing word is written now, and
                        // the cache copy only when the line already holds it.
                        stateNext = MISS_WAIT;
                        cntNext   = CNT_W'(MISS_LAT);
                        accept    = 1'b1;
                        memWe     = 1'b1;
                        cacheWe   = inHit;
                        Stall     = 1'b1;
                    end
                end
            end

            MISS_WAIT: begin
                Stall = 1'b1;
                if (!reqWrite && cancel) begin
                    stateNext = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    stateNext = RESP;
                    doneNext  = 1'b1;
                    hitNext   = reqHit;
                    if (!reqWrite) begin
                        fill     = 1'b1;
                        dataNext = memRdata;
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end

            RESP: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, request latch, valid bits and registered response outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before this edge.
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            reqWord   <= '0;
            reqWrite  <= 1'b0;
            reqHit    <= 1'b0;
            validBits <= '0;
            Done      <= 1'b0;
            CacheHit  <= 1'b0;
            err       <= 1'b0;
            DataOut   <= 16'h0000;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            Done     <= doneNext;
            CacheHit <= hitNext;
            err      <= errNext;
            DataOut  <= dataNext;
            if (accept) begin
                reqWord  <= inWord;
                reqWrite <= Wr;
                reqHit   <= inHit;
            end
            if (fill) begin
                validBits[reqIndex] <= 1'b1;
            end
        end
    end

    // Cache tag/data and backing array writes.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset. The valid bits alone decide
        // whether cache contents are used, and the backing array keeps its
        // data across reset.
        if (rst) begin
            if (memWe) begin
                mem[inWord] <= DataIn;
            end
            if (cacheWe) begin
                dataArr[inIndex] <= DataIn;
            end
            if (fill) begin
                tagArr[reqIndex]  <= reqTag;
                dataArr[reqIndex] <= memRdata;
            end
        end
    end

endmodule
